// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: registered divided clock, its complement and a
// once-per-period tick, with a pending divisor register applied at period boundaries.
module clk_div_prog #(
  parameter int W        = 16,
  parameter int DIV_INIT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] cfg_div,
  input  logic         cfg_load,
  output logic         cfg_busy,
  output logic [W-1:0] div_active,
  output logic         cfg_clamped,
  output logic         div_clk,
  output logic         div_clk_n,
  output logic         tick
);

  localparam logic [W-1:0] DIV_RESET = W'(DIV_INIT);
  localparam logic [W-1:0] DIV_MIN   = W'(2);

  logic [W-1:0] p;
  logic [W-1:0] pending;
  logic [W-1:0] half;
  logic [W-1:0] last_p;
  logic         boundary;
  logic         apply;
  logic         high_phase;

  // High phase lasts ceil(N/2) cycles, so odd divisors lean high.
  assign half       = (div_active >> 1) + W'(div_active[0]);
  assign last_p     = div_active - W'(1);
  assign high_phase = (p < half);
  assign boundary   = en && (p == last_p);
  assign apply      = cfg_busy && (!en || boundary);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= '0;
      div_clk   <= 1'b0;
      div_clk_n <= 1'b1;
      tick      <= 1'b0;
    end else if (en) begin
      p         <= boundary ? '0 : p + W'(1);
      div_clk   <= high_phase;
      div_clk_n <= ~high_phase;
      tick      <= boundary;
    end else begin
      p         <= '0;
      div_clk   <= 1'b0;
      div_clk_n <= 1'b1;
      tick      <= 1'b0;
    end
  end

  // A load on an apply edge re-arms busy, so the later assignment must win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      cfg_busy    <= 1'b0;
      cfg_clamped <= 1'b0;
      div_active  <= DIV_RESET;
    end else begin
      if (apply) begin
        div_active  <= (pending < DIV_MIN) ? DIV_MIN : pending;
        cfg_clamped <= (pending < DIV_MIN);
        cfg_busy    <= 1'b0;
      end
      if (cfg_load) begin
        pending  <= cfg_div;
        cfg_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios followed by random loads, enable drops and
// resets, all compared against a period-pattern queue model.
module tb_clk_div_prog;

  localparam int W        = 16;
  localparam int DIV_INIT = 8;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         en       = 1'b0;
  logic         cfg_load = 1'b0;
  logic [W-1:0] cfg_div  = '0;
  logic         cfg_busy;
  logic [W-1:0] div_active;
  logic         cfg_clamped;
  logic         div_clk;
  logic         div_clk_n;
  logic         tick;

  clk_div_prog #(.W(W), .DIV_INIT(DIV_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_div(cfg_div), .cfg_load(cfg_load),
    .cfg_busy(cfg_busy), .div_active(div_active), .cfg_clamped(cfg_clamped),
    .div_clk(div_clk), .div_clk_n(div_clk_n), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // The model holds the remaining slots of the current output period as a queue.
  typedef struct { bit high; bit last; } slot_t;
  slot_t period_q[$];
  int    m_active;
  int    m_pending;
  bit    m_busy, m_clamped, m_clk, m_tick;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    period_q.delete();
    m_active  = DIV_INIT;
    m_pending = 0;
    m_busy    = 0;
    m_clamped = 0;
    m_clk     = 0;
    m_tick    = 0;
  endtask

  task automatic model_edge(input bit e, input bit ld, input int dv);
    bit    do_apply = 0;
    slot_t s;
    if (e) begin
      if (period_q.size() == 0)
        for (int i = 0; i < m_active; i++) begin
          s.high = (2 * i < m_active);
          s.last = (i == m_active - 1);
          period_q.push_back(s);
        end
      s      = period_q.pop_front();
      m_clk  = s.high;
      m_tick = s.last;
      if (period_q.size() == 0 && m_busy) do_apply = 1;
    end else begin
      period_q.delete();
      m_clk  = 0;
      m_tick = 0;
      if (m_busy) do_apply = 1;
    end
    if (do_apply) begin
      m_active  = (m_pending < 2) ? 2 : m_pending;
      m_clamped = (m_pending < 2);
      m_busy    = 0;
    end
    if (ld) begin
      m_pending = dv;
      m_busy    = 1;
    end
  endtask

  task automatic check_all();
    checkOutput("div_clk", 32'(div_clk), 32'(m_clk));
    checkOutput("div_clk_n", 32'(div_clk_n), 32'(!m_clk));
    checkOutput("tick", 32'(tick), 32'(m_tick));
    checkOutput("cfg_busy", 32'(cfg_busy), 32'(m_busy));
    checkOutput("div_active", 32'(div_active), 32'(m_active));
    checkOutput("cfg_clamped", 32'(cfg_clamped), 32'(m_clamped));
  endtask

  task automatic applyStimulus(input bit e, input bit ld, input int dv);
    en       = e;
    cfg_load = ld;
    cfg_div  = W'(dv);
    @(posedge clk);
    model_edge(e, ld, dv);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 0);
  endtask

  // Runs until the model has just passed a period boundary; the next edge is p=0.
  task automatic sync_boundary();
    int budget = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 0);
      budget++;
    end while (!m_tick && budget < 200);
    if (!m_tick) checkOutput("sync_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_div_clk", 32'(div_clk), 32'd0);
    checkOutput("rst_div_clk_n", 32'(div_clk_n), 32'd1);
    checkOutput("rst_busy", 32'(cfg_busy), 32'd0);
    checkOutput("rst_tick", 32'(tick), 32'd0);
    checkOutput("rst_clamped", 32'(cfg_clamped), 32'd0);
    checkOutput("rst_div_active", 32'(div_active), 32'(DIV_INIT));
    model_reset();
    en       = 1'b0;
    cfg_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    checkOutput("init_div_clk", 32'(div_clk), 32'd0);
    checkOutput("init_div_clk_n", 32'(div_clk_n), 32'd1);
    checkOutput("init_div_active", 32'(div_active), 32'(DIV_INIT));
    checkOutput("init_busy", 32'(cfg_busy), 32'd0);
    rst_n = 1'b1;

    run(24);

    sync_boundary();
    run(2);
    applyStimulus(1'b1, 1'b1, 5);
    run(20);

    sync_boundary();
    applyStimulus(1'b1, 1'b1, 0);
    run(10);
    applyStimulus(1'b1, 1'b1, 3);
    run(12);

    sync_boundary();
    applyStimulus(1'b1, 1'b1, 6);
    run(1);
    applyStimulus(1'b1, 1'b1, 10);
    run(30);

    applyStimulus(1'b1, 1'b1, 8);
    run(20);
    sync_boundary();
    run(1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0);
    run(12);

    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b0, 1'b0, 0);
    run(10);

    sync_boundary();
    applyStimulus(1'b1, 1'b1, 7);
    run(1);
    do_reset();
    run(20);

    for (int i = 0; i < 2000; i++) begin
      bit e  = ($urandom_range(0, 9) != 0);
      bit ld = ($urandom_range(0, 11) == 0);
      int dv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12);
      if ($urandom_range(0, 299) == 0) do_reset();
      else applyStimulus(e, ld, dv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
